// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {StInit, StRun} state_e;

    localparam int unsigned MaxRead  = 4;
    localparam int unsigned MaxWrite = 2;
    // Widest address the winner search handles; callers zero-extend into it.
    localparam int unsigned MaxAddrW = 16;
    localparam int unsigned WinIdxW  = 1;

    typedef struct packed {
        logic               hit;
        logic [WinIdxW-1:0] idx;
    } win_t;

    // Highest-indexed enabled write port targeting addr, if any.
    function automatic win_t win_port(input logic [MaxWrite-1:0]               we,
                                      input logic [MaxWrite-1:0][MaxAddrW-1:0] wa,
                                      input logic [MaxAddrW-1:0]               addr);
        win_t w;
        w.hit = 1'b0;
        w.idx = '0;
        for (int p = 0; p < MaxWrite; p++) begin
            if (we[p] && (wa[p] == addr)) begin
                w.hit = 1'b1;
                w.idx = p[WinIdxW-1:0];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Port bundle of the register file: control, read ports and write ports.
interface regfile_mp_if #(
    parameter int unsigned RWIDTH = 6,
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 1
) ();
    logic                           clr;
    logic                           ready;
    logic [NREAD-1:0]               re;
    logic [NREAD-1:0][RWIDTH-1:0]   ra;
    logic [NREAD-1:0][DWIDTH-1:0]   rd;
    logic [NWRITE-1:0]              we;
    logic [NWRITE-1:0][RWIDTH-1:0]  wa;
    logic [NWRITE-1:0][DWIDTH-1:0]  wd;

    modport master (output clr, re, ra, we, wa, wd, input ready, rd);
    modport slave  (input clr, re, ra, we, wa, wd, output ready, rd);
endinterface

// File: rtl/regfile_bypass_sel.sv
// Per-read-port data select: write-first bypass, then zero-register masking.
module regfile_bypass_sel
    import regfile_pkg::*;
#(
    parameter int unsigned RWIDTH   = 6,
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned NWRITE   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [RWIDTH-1:0]              ra_i,
    input  logic [NWRITE-1:0]              we_i,
    input  logic [NWRITE-1:0][RWIDTH-1:0]  wa_i,
    input  logic [NWRITE-1:0][DWIDTH-1:0]  wd_i,
    input  logic [DWIDTH-1:0]              mem_i,
    output logic [DWIDTH-1:0]              rd_o
);
    logic [MaxWrite-1:0]               we_pad;
    logic [MaxWrite-1:0][MaxAddrW-1:0] wa_pad;
    logic [MaxWrite-1:0][DWIDTH-1:0]   wd_pad;
    win_t                              win;

    // Widen ports to the package maximum, pick the winner, mask entry 0.
    always_comb begin
        we_pad = '0;
        wa_pad = '0;
        wd_pad = '0;
        for (int p = 0; p < NWRITE; p++) begin
            we_pad[p] = we_i[p];
            wa_pad[p] = MaxAddrW'(wa_i[p]);
            wd_pad[p] = wd_i[p];
        end
        win  = win_port(we_pad, wa_pad, MaxAddrW'(ra_i));
        rd_o = win.hit ? wd_pad[win.idx] : mem_i;
        if ((ZERO_REG != 0) && (ra_i == '0)) begin
            rd_o = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with clear sweep, write-first bypass and zero register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned RWIDTH   = 6,
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned NWRITE   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input logic       clk,
    input logic       rst_n,
    regfile_mp_if.slave bus
);
    localparam int unsigned Depth = 1 << RWIDTH;
    localparam int unsigned NRd   = (NREAD < MaxRead) ? NREAD : MaxRead;

    state_e                       state_q, state_d;
    logic [RWIDTH-1:0]            cnt_q, cnt_d;
    logic                         ready_q, ready_d;
    logic [NREAD-1:0][DWIDTH-1:0] rd_q, rd_d;
    logic [NREAD-1:0][DWIDTH-1:0] byp;
    logic [NWRITE-1:0]            we_eff;
    logic [DWIDTH-1:0]            mem_q [Depth];

    // Writes dropped by the FSM must not be forwarded either.
    assign we_eff = bus.we & {NWRITE{(state_q == StRun) && !bus.clr}};

    for (genvar i = 0; i < NRd; i++) begin : g_rd
        regfile_bypass_sel #(
            .RWIDTH   (RWIDTH),
            .DWIDTH   (DWIDTH),
            .NWRITE   (NWRITE),
            .ZERO_REG (ZERO_REG)
        ) u_bypass_sel (
            .ra_i  (bus.ra[i]),
            .we_i  (we_eff),
            .wa_i  (bus.wa),
            .wd_i  (bus.wd),
            .mem_i (mem_q[bus.ra[i]]),
            .rd_o  (byp[i])
        );
    end

    // Sweep counter and INIT/RUN sequencing; clr always restarts the sweep.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.clr) begin
            state_d = StInit;
            cnt_d   = '0;
        end else if (state_q == StInit) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == RWIDTH'(Depth - 1)) begin
                state_d = StRun;
            end
        end
        ready_d = (state_d == StRun);
    end

    // Read data registers: zero during the sweep, hold when not enabled.
    always_comb begin
        rd_d = rd_q;
        for (int i = 0; i < NRd; i++) begin
            if (bus.re[i]) begin
                rd_d[i] = (state_q == StRun) ? byp[i] : '0;
            end
        end
    end

    // Control and read-data state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rd_q    <= rd_d;
        end
    end

    // Storage has no reset; later ports overwrite earlier ones on a conflict.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem_q[cnt_q] <= '0;
        end else if (!bus.clr) begin
            for (int p = 0; p < NWRITE; p++) begin
                if (bus.we[p] && !((ZERO_REG != 0) && (bus.wa[p] == '0))) begin
                    mem_q[bus.wa[p]] <= bus.wd[p];
                end
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.rd    = rd_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against a behavioural model.
module tb_regfile_mp;
    localparam int unsigned RW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;
    localparam int unsigned Depth = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    regfile_mp_if #(.RWIDTH(RW), .DWIDTH(DW), .NREAD(NR), .NWRITE(NW)) bus ();

    regfile_mp #(
        .RWIDTH   (RW),
        .DWIDTH   (DW),
        .NREAD    (NR),
        .NWRITE   (NW),
        .ZERO_REG (1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] m_mem [Depth];
    logic [DW-1:0] m_rd  [NR];
    bit            m_run;
    int            m_cnt;

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < NR; i++) m_rd[i] = '0;
    endtask

    // Apply one rising edge's worth of the register-file rules to the model.
    task automatic model_step();
        logic [DW-1:0] v;
        if (!m_run) begin
            for (int i = 0; i < NR; i++) if (bus.re[i]) m_rd[i] = '0;
            m_mem[m_cnt] = '0;
            if (bus.clr) m_cnt = 0;
            else if (m_cnt == Depth - 1) begin
                m_run = 1'b1;
                m_cnt = 0;
            end else m_cnt++;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (bus.re[i]) begin
                    v = m_mem[int'(bus.ra[i])];
                    if (!bus.clr)
                        for (int p = 0; p < NW; p++)
                            if (bus.we[p] && bus.wa[p] == bus.ra[i]) v = bus.wd[p];
                    if (bus.ra[i] == 0) v = '0;
                    m_rd[i] = v;
                end
            end
            if (!bus.clr) begin
                for (int p = 0; p < NW; p++)
                    if (bus.we[p] && bus.wa[p] != 0) m_mem[int'(bus.wa[p])] = bus.wd[p];
            end else begin
                m_run = 1'b0;
                m_cnt = 0;
            end
        end
    endtask

    // One clock: model consumes the inputs the DUT samples, then compare.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_eq("ready", {31'b0, bus.ready}, {31'b0, m_run});
        check_eq("rd0", bus.rd[0], m_rd[0]);
        check_eq("rd1", bus.rd[1], m_rd[1]);
    endtask

    task automatic idle();
        bus.clr = 1'b0;
        bus.re  = '0;
        bus.we  = '0;
    endtask

    task automatic rand_inputs(input bit allow_clr);
        for (int i = 0; i < NR; i++) begin
            bus.ra[i] = ($urandom_range(0, 3) == 0) ? RW'($urandom) : RW'($urandom_range(0, 7));
        end
        for (int p = 0; p < NW; p++) begin
            bus.wa[p] = ($urandom_range(0, 3) == 0) ? RW'($urandom) : RW'($urandom_range(0, 7));
            bus.wd[p] = $urandom;
        end
        bus.we  = NW'($urandom);
        bus.clr = allow_clr && ($urandom_range(0, 59) == 0);
        bus.re  = bus.clr ? '0 : NR'($urandom);
    endtask

    initial begin
        idle();
        bus.ra = '0;
        bus.wa = '0;
        bus.wd = '0;
        model_reset();

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'b0, bus.ready}, '0);
        check_eq("rst_rd0", bus.rd[0], '0);
        check_eq("rst_rd1", bus.rd[1], '0);
        rst_n = 1'b1;

        // Sweep with random traffic; writes must be ignored
        for (int k = 0; k < Depth; k++) begin
            rand_inputs(1'b0);
            cycle();
        end
        check_eq("sweep_done", {31'b0, bus.ready}, 32'd1);

        // Every entry reads zero after the sweep
        idle();
        for (int a = 0; a < 32; a++) begin
            bus.re    = 2'b11;
            bus.ra[0] = RW'(a);
            bus.ra[1] = RW'(a + 32);
            cycle();
            check_eq("clr_lo", bus.rd[0], '0);
            check_eq("clr_hi", bus.rd[1], '0);
        end

        // Write then read next cycle
        idle();
        bus.we[0] = 1'b1; bus.wa[0] = 6'd5; bus.wd[0] = 32'hDEADBEEF;
        cycle();
        idle();
        bus.re[0] = 1'b1; bus.ra[0] = 6'd5;
        cycle();
        check_eq("r5", bus.rd[0], 32'hDEADBEEF);

        // Same-cycle bypass
        idle();
        bus.we[0] = 1'b1; bus.wa[0] = 6'd7; bus.wd[0] = 32'h12345678;
        bus.re[0] = 1'b1; bus.ra[0] = 6'd7;
        cycle();
        check_eq("byp_r7", bus.rd[0], 32'h12345678);

        // Zero register: same-cycle and later read
        idle();
        bus.we[0] = 1'b1; bus.wa[0] = 6'd0; bus.wd[0] = 32'hFFFFFFFF;
        bus.re[1] = 1'b1; bus.ra[1] = 6'd0;
        cycle();
        check_eq("r0_byp", bus.rd[1], '0);
        idle();
        bus.re[0] = 1'b1; bus.ra[0] = 6'd0;
        cycle();
        check_eq("r0", bus.rd[0], '0);

        // Write conflict: port 1 wins, also through the bypass
        idle();
        bus.we = 2'b11;
        bus.wa[0] = 6'd9; bus.wd[0] = 32'h1111;
        bus.wa[1] = 6'd9; bus.wd[1] = 32'h2222;
        bus.re[1] = 1'b1; bus.ra[1] = 6'd9;
        cycle();
        check_eq("conf_byp", bus.rd[1], 32'h2222);
        idle();
        bus.re[0] = 1'b1; bus.ra[0] = 6'd9;
        cycle();
        check_eq("conf_r9", bus.rd[0], 32'h2222);

        // Fill r3, read it, then hold with re=0
        idle();
        bus.we[0] = 1'b1; bus.wa[0] = 6'd3; bus.wd[0] = 32'hA5A5A5A5;
        cycle();
        idle();
        bus.re[0] = 1'b1; bus.ra[0] = 6'd3;
        cycle();
        check_eq("r3", bus.rd[0], 32'hA5A5A5A5);
        for (int k = 0; k < 5; k++) begin
            rand_inputs(1'b0);
            bus.re = '0;
            cycle();
            check_eq("hold", bus.rd[0], 32'hA5A5A5A5);
        end

        // clr pulse, then reset at cnt=20 mid-sweep
        idle();
        bus.clr = 1'b1;
        cycle();
        check_eq("clr_ready", {31'b0, bus.ready}, '0);
        for (int k = 0; k < 20; k++) begin
            rand_inputs(1'b0);
            bus.re = '0;
            cycle();
        end
        check_eq("hold_init", bus.rd[0], 32'hA5A5A5A5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rd0", bus.rd[0], '0);
        check_eq("async_ready", {31'b0, bus.ready}, '0);
        model_reset();
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < Depth; k++) begin
            rand_inputs(1'b0);
            cycle();
            if (k == Depth - 2) check_eq("sweep_63", {31'b0, bus.ready}, '0);
        end
        check_eq("sweep2_done", {31'b0, bus.ready}, 32'd1);
        idle();
        bus.re[0] = 1'b1; bus.ra[0] = 6'd3;
        cycle();
        check_eq("r3_cleared", bus.rd[0], '0);

        // Random traffic with occasional clr
        for (int k = 0; k < 600; k++) begin
            rand_inputs(1'b1);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
